// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//   A bank of NCH independent timers sharing one free-running prescaler.
//   Each channel runs in one of these modes:
//     ASTABLE (0, also 3): square wave. Phase A drives out high and phase B
//                          drives it low. Runs until stopped.
//     PULSE   (1)        : out high for phase A, then the channel stops itself
//                          and sets done.
//     DELAY   (2)        : out low for phase A, then out goes high, done is set
//                          and the channel holds until stopped.
//   A phase lasts period+1 ticks. The channel tick is taken from the low
//   'div' bits of the shared prescaler.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ch/op     command port: op=1 start/restart, op=0 stop
//   cfg_we/ch/sel/data  config port: sel 0=period_a, 1=period_b,
//                       2={mode[1:0],div[DIV_W-1:0]}, 3=ignored
//   rd_ch               channel whose phase counter appears on rd_count
//   tmr_out             registered timer outputs
//   tmr_active          registered running flags
//   tmr_done            registered sticky completion flags
//   rd_count            combinational phase counter of channel rd_ch
// -----------------------------------------------------------------------------
module timer_bank #(
   parameter int NCH     = 4,
   parameter int CNT_W   = 10,
   parameter int PRESC_W = 8,
   parameter int DIV_W   = 4,
   localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   input  logic [CH_W-1:0]  cmd_ch,
   input  logic             cmd_op,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [1:0]       cfg_sel,
   input  logic [CNT_W-1:0] cfg_data,
   input  logic [CH_W-1:0]  rd_ch,
   output logic [NCH-1:0]   tmr_out,
   output logic [NCH-1:0]   tmr_active,
   output logic [NCH-1:0]   tmr_done,
   output logic [CNT_W-1:0] rd_count
);

   localparam logic [1:0] MODE_PULSE = 2'd1;
   localparam logic [1:0] MODE_DELAY = 2'd2;

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [CNT_W-1:0]   cnt_q [NCH];
   logic [CNT_W-1:0]   cnt_d [NCH];
   logic [CNT_W-1:0]   pa_q  [NCH];
   logic [CNT_W-1:0]   pa_d  [NCH];
   logic [CNT_W-1:0]   pb_q  [NCH];
   logic [CNT_W-1:0]   pb_d  [NCH];
   logic [DIV_W-1:0]   div_q [NCH];
   logic [DIV_W-1:0]   div_d [NCH];
   logic [1:0]         mode_q [NCH];
   logic [1:0]         mode_d [NCH];
   logic [NCH-1:0]     phase_q, phase_d;   // 0 = phase A, 1 = phase B
   logic [NCH-1:0]     out_q, out_d;
   logic [NCH-1:0]     active_q, active_d;
   logic [NCH-1:0]     done_q, done_d;

   // Channel tick: the low 'div' prescaler bits are all ones. Divisors above
   // PRESC_W clamp to the full prescaler width.
   function automatic logic tick_of(input logic [PRESC_W-1:0] presc,
                                    input logic [DIV_W-1:0]   div);
      logic [PRESC_W-1:0] mask;
      int                 d;
      d    = (int'(div) > PRESC_W) ? PRESC_W : int'(div);
      mask = ~({PRESC_W{1'b1}} << d);
      return (presc & mask) == mask;
   endfunction

   always_comb begin
      presc_d = presc_q + 1'b1;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i]    = cnt_q[i];
         pa_d[i]     = pa_q[i];
         pb_d[i]     = pb_q[i];
         div_d[i]    = div_q[i];
         mode_d[i]   = mode_q[i];
         phase_d[i]  = phase_q[i];
         out_d[i]    = out_q[i];
         active_d[i] = active_q[i];
         done_d[i]   = done_q[i];

         if (cfg_we && int'(cfg_ch) == i) begin
            case (cfg_sel)
               2'd0:    pa_d[i] = cfg_data;
               2'd1:    pb_d[i] = cfg_data;
               2'd2: begin
                  div_d[i]  = cfg_data[DIV_W-1:0];
                  mode_d[i] = cfg_data[DIV_W+1:DIV_W];
               end
               default: ;
            endcase
         end

         // Commands override a tick on the same cycle. A start sees a mode
         // written on the same cycle because it decodes mode_d.
         if (cmd_valid && int'(cmd_ch) == i) begin
            if (cmd_op) begin
               cnt_d[i]    = '0;
               phase_d[i]  = 1'b0;
               active_d[i] = 1'b1;
               done_d[i]   = 1'b0;
               out_d[i]    = (mode_d[i] != MODE_DELAY);
            end else if (active_q[i]) begin
               cnt_d[i]    = '0;
               phase_d[i]  = 1'b0;
               active_d[i] = 1'b0;
               out_d[i]    = 1'b0;
            end
         end else if (active_q[i] && tick_of(presc_q, div_q[i])) begin
            // A completed DELAY channel parks in phase B with cnt frozen.
            if (!(mode_q[i] == MODE_DELAY && phase_q[i])) begin
               if (cnt_q[i] >= (phase_q[i] ? pb_q[i] : pa_q[i])) begin
                  cnt_d[i] = '0;
                  case (mode_q[i])
                     MODE_PULSE: begin
                        out_d[i]    = 1'b0;
                        active_d[i] = 1'b0;
                        done_d[i]   = 1'b1;
                        phase_d[i]  = 1'b0;
                     end
                     MODE_DELAY: begin
                        out_d[i]   = 1'b1;
                        done_d[i]  = 1'b1;
                        phase_d[i] = 1'b1;
                     end
                     default: begin
                        phase_d[i] = ~phase_q[i];
                        out_d[i]   = phase_q[i];
                     end
                  endcase
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q  <= '0;
         phase_q  <= '0;
         out_q    <= '0;
         active_q <= '0;
         done_q   <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]  <= '0;
            pa_q[i]   <= CNT_W'(2);
            pb_q[i]   <= CNT_W'(3);
            div_q[i]  <= '0;
            mode_q[i] <= 2'd0;
         end
      end else begin
         presc_q  <= presc_d;
         phase_q  <= phase_d;
         out_q    <= out_d;
         active_q <= active_d;
         done_q   <= done_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]  <= cnt_d[i];
            pa_q[i]   <= pa_d[i];
            pb_q[i]   <= pb_d[i];
            div_q[i]  <= div_d[i];
            mode_q[i] <= mode_d[i];
         end
      end
   end

   always_comb begin
      rd_count = '0;
      for (int i = 0; i < NCH; i++) begin
         if (int'(rd_ch) == i) rd_count = cnt_q[i];
      end
   end

   assign tmr_out    = out_q;
   assign tmr_active = active_q;
   assign tmr_done   = done_q;

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
//   Scoreboard bench for timer_bank. The stimulus pushes an expected value for
//   a given cycle, signal and channel. A negedge monitor pops entries as their
//   cycle arrives and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_timer_bank;
   localparam int NCH = 4, CNT_W = 10, PRESC_W = 8, DIV_W = 4;
   localparam int W_OUT = 0, W_ACT = 1, W_DONE = 2, W_CNT = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid, cmd_op, cfg_we;
   logic [1:0]       cmd_ch, cfg_ch, rd_ch, cfg_sel;
   logic [CNT_W-1:0] cfg_data;
   logic [NCH-1:0]   tmr_out, tmr_active, tmr_done;
   logic [CNT_W-1:0] rd_count;

   timer_bank #(.NCH(NCH), .CNT_W(CNT_W), .PRESC_W(PRESC_W), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_op(cmd_op),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .rd_ch(rd_ch),
      .tmr_out(tmr_out), .tmr_active(tmr_active), .tmr_done(tmr_done),
      .rd_count(rd_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;        // number of posedges so far
   int rst_rel = 0;    // cyc value when rst_n was last released
   int n_checks = 0;
   int n_fail = 0;

   int    q_when[$];
   int    q_what[$];
   int    q_idx[$];
   int    q_exp[$];
   string q_tag[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_exp(input int when, input int what, input int idx,
                           input int exp, input string tag);
      q_when.push_back(when);
      q_what.push_back(what);
      q_idx.push_back(idx);
      q_exp.push_back(exp);
      q_tag.push_back(tag);
   endtask

   function automatic logic [31:0] sample(input int what, input int idx);
      case (what)
         W_OUT:   return 32'(tmr_out[idx]);
         W_ACT:   return 32'(tmr_active[idx]);
         W_DONE:  return 32'(tmr_done[idx]);
         default: return 32'(rd_count);
      endcase
   endfunction

   always @(negedge clk) begin
      int k;
      k = 0;
      while (k < q_when.size()) begin
         if (q_when[k] == cyc) begin
            check(q_tag[k], sample(q_what[k], q_idx[k]), q_exp[k]);
            q_when.delete(k);
            q_what.delete(k);
            q_idx.delete(k);
            q_exp.delete(k);
            q_tag.delete(k);
         end else begin
            k++;
         end
      end
   end

   // Edge at which the n-th channel tick after edge 'start' occurs. The
   // prescaler holds (c-1-rst_rel) mod 256 just before edge c.
   function automatic int nth_tick(input int start, input int n, input int div);
      int c, cnt, mask;
      c    = start;
      cnt  = 0;
      mask = (1 << div) - 1;
      while (cnt < n) begin
         c++;
         if ((((c - 1 - rst_rel) & 255) & mask) == mask) cnt++;
      end
      return c;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) step(1);
   endtask

   task automatic do_cmd(input int ch, input int op);
      cmd_ch = 2'(ch); cmd_op = op[0]; cmd_valid = 1'b1;
      step(1);
      cmd_valid = 1'b0;
   endtask

   task automatic do_cfg(input int ch, input int sel, input int data);
      cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = CNT_W'(data); cfg_we = 1'b1;
      step(1);
      cfg_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int s, s0, e, p, t1, t6, t8, t9, budget;
      cmd_valid = 1'b0; cmd_op = 1'b0; cmd_ch = '0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0; rd_ch = '0;

      // Reset state
      step(3);
      for (int i = 0; i < NCH; i++) begin
         push_exp(cyc, W_OUT, i, 0, "rst_out");
         push_exp(cyc, W_ACT, i, 0, "rst_active");
         push_exp(cyc, W_DONE, i, 0, "rst_done");
      end
      push_exp(cyc, W_CNT, 0, 0, "rst_count");
      step(1);
      rst_n = 1'b1; rst_rel = cyc;
      step(1);

      // 1: ASTABLE ch0 with defaults: high 3, low 4
      do_cmd(0, 1); s = cyc; s0 = s;
      push_exp(s,      W_OUT, 0, 1, "ast_hi_first");
      push_exp(s + 2,  W_OUT, 0, 1, "ast_hi_last");
      push_exp(s + 3,  W_OUT, 0, 0, "ast_lo_first");
      push_exp(s + 6,  W_OUT, 0, 0, "ast_lo_last");
      push_exp(s + 7,  W_OUT, 0, 1, "ast_hi_again");
      push_exp(s + 10, W_OUT, 0, 0, "ast_lo_again");
      push_exp(s,      W_ACT, 0, 1, "ast_active");
      push_exp(s,      W_DONE, 0, 0, "ast_done");

      // 2: PULSE ch1, period_a=5, div=2
      do_cfg(1, 0, 5);
      do_cfg(1, 2, (1 << DIV_W) | 2);
      do_cmd(1, 1); s = cyc;
      t6 = nth_tick(s, 6, 2);
      push_exp(s,      W_OUT, 1, 1, "pulse_start");
      push_exp(s,      W_DONE, 1, 0, "pulse_done_clr");
      push_exp(t6 - 1, W_OUT, 1, 1, "pulse_hi_end");
      push_exp(t6 - 1, W_ACT, 1, 1, "pulse_act_end");
      push_exp(t6,     W_OUT, 1, 0, "pulse_fall");
      push_exp(t6,     W_ACT, 1, 0, "pulse_idle");
      push_exp(t6,     W_DONE, 1, 1, "pulse_done");
      wait_until(t6 + 1);

      // 3: DELAY ch2; mode written in the same cycle as the start
      do_cfg(2, 0, 3);
      cfg_ch = 2'd2; cfg_sel = 2'd2; cfg_data = CNT_W'(2 << DIV_W); cfg_we = 1'b1;
      cmd_ch = 2'd2; cmd_op = 1'b1; cmd_valid = 1'b1;
      step(1);
      cfg_we = 1'b0; cmd_valid = 1'b0;
      s = cyc; rd_ch = 2'd2;
      push_exp(s,      W_OUT, 2, 0, "delay_start_low");
      push_exp(s + 3,  W_OUT, 2, 0, "delay_still_low");
      push_exp(s + 3,  W_CNT, 2, 3, "delay_cnt3");
      push_exp(s + 4,  W_OUT, 2, 1, "delay_rise");
      push_exp(s + 4,  W_DONE, 2, 1, "delay_done");
      push_exp(s + 15, W_OUT, 2, 1, "delay_hold");
      push_exp(s + 15, W_ACT, 2, 1, "delay_active");
      push_exp(s + 15, W_CNT, 2, 0, "delay_frozen");
      wait_until(s + 19);
      do_cmd(2, 0); p = cyc;
      push_exp(p, W_OUT, 2, 0, "delay_stop_out");
      push_exp(p, W_ACT, 2, 0, "delay_stop_act");
      push_exp(p, W_DONE, 2, 1, "delay_stop_done");
      step(1);

      // 4: restart ch0 in phase B at cnt=2, then stop against a tick
      rd_ch = 2'd0;
      e = cyc + 2;
      while (((e - 1 - s0) % 7) != 5) e++;
      push_exp(e - 1, W_CNT, 0, 2, "restart_pre_cnt");
      push_exp(e - 1, W_OUT, 0, 0, "restart_pre_out");
      wait_until(e - 1);
      do_cmd(0, 1);
      push_exp(e,     W_CNT, 0, 0, "restart_cnt");
      push_exp(e,     W_OUT, 0, 1, "restart_out");
      push_exp(e,     W_DONE, 0, 0, "restart_done");
      push_exp(e + 2, W_OUT, 0, 1, "restart_hi");
      push_exp(e + 3, W_OUT, 0, 0, "restart_lo");
      wait_until(e + 4);
      do_cmd(0, 0); p = cyc;
      push_exp(p,     W_OUT, 0, 0, "stop_out");
      push_exp(p,     W_ACT, 0, 0, "stop_act");
      push_exp(p,     W_CNT, 0, 0, "stop_cnt");
      push_exp(p + 3, W_OUT, 0, 0, "stop_held");
      push_exp(p + 3, W_CNT, 0, 0, "stop_cnt_held");
      do_cmd(1, 0); p = cyc;
      push_exp(p, W_DONE, 1, 1, "idle_stop_done");
      push_exp(p, W_ACT, 1, 0, "idle_stop_act");
      step(4);

      // 5: lower period_a of ch3 below its running count
      do_cfg(3, 0, 10);
      do_cfg(3, 2, 1);
      do_cmd(3, 1); s = cyc; rd_ch = 2'd3;
      t8 = nth_tick(s, 8, 1);
      t9 = nth_tick(s, 9, 1);
      push_exp(t8,     W_CNT, 3, 8, "shrink_cnt8");
      push_exp(t8 + 1, W_CNT, 3, 8, "shrink_cnt8_w");
      push_exp(t8 + 1, W_OUT, 3, 1, "shrink_out_w");
      push_exp(t9,     W_CNT, 3, 0, "shrink_cnt0");
      push_exp(t9,     W_OUT, 3, 0, "shrink_fall");
      push_exp(nth_tick(s, 10, 1), W_CNT, 3, 1, "shrink_phase_b");
      wait_until(t8);
      do_cfg(3, 0, 4);
      wait_until(t9 + 3);

      // 6: wide divisors, then asynchronous reset mid-count
      do_cfg(0, 2, PRESC_W);
      do_cfg(1, 2, 15);
      do_cfg(2, 2, 0);
      do_cmd(0, 1);
      do_cmd(1, 1); s = cyc; rd_ch = 2'd1;
      do_cmd(2, 1);
      do_cmd(3, 1);
      t1 = nth_tick(s, 1, PRESC_W);
      push_exp(t1 - 1, W_CNT, 1, 0, "clamp_pre_tick");
      push_exp(t1,     W_CNT, 1, 1, "clamp_tick");
      push_exp(t1,     W_OUT, 1, 1, "clamp_out");
      wait_until(t1 + 1);
      check("pre_rst_active", 32'(tmr_active), 32'hf);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_out", 32'(tmr_out), 0);
      check("async_active", 32'(tmr_active), 0);
      check("async_done", 32'(tmr_done), 0);
      check("async_count", 32'(rd_count), 0);
      step(2);
      rst_n = 1'b1; rst_rel = cyc;
      step(1);
      do_cmd(0, 1); s = cyc;
      push_exp(s + 2, W_OUT, 0, 1, "dflt_hi");
      push_exp(s + 3, W_OUT, 0, 0, "dflt_lo");
      push_exp(s + 7, W_OUT, 0, 1, "dflt_period");
      do_cmd(2, 1); s = cyc;
      push_exp(s, W_OUT, 2, 1, "dflt_mode");
      push_exp(s, W_DONE, 2, 0, "dflt_done");
      do_cmd(1, 1); s = cyc;
      push_exp(s + 1, W_CNT, 1, 1, "dflt_div");

      budget = 0;
      while (q_when.size() > 0 && budget < 3000) begin
         step(1);
         budget++;
      end
      check("scoreboard_drain", 32'(q_when.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
